// File: rtl/secuenciador_pkg.sv
// secuenciador_pkg: shared definitions for the sample scheduler.
//   estado_t        - scheduler FSM state encoding (2 bits)
//   DIV_DEF         - default sample period in clock cycles
//   TIMEOUT_ADC_DEF - default ADC handshake limit in cycles
//   TIMEOUT_FILTRO_DEF - default filter handshake limit in cycles
package secuenciador_pkg;

  typedef enum logic [1:0] {
    REPOSO       = 2'd0,
    CONVIRTIENDO = 2'd1,
    FILTRANDO    = 2'd2
  } estado_t;

  localparam int DIV_DEF            = 1000;
  localparam int TIMEOUT_ADC_DEF    = 64;
  localparam int TIMEOUT_FILTRO_DEF = 32;

endpackage

// File: rtl/divisor_muestreo.sv
// divisor_muestreo: sample-period counter.
//   Clk       in  system clock
//   Reset     in  synchronous active-high reset
//   Habilitar in  counts while 1, counter held at 0 while 0
//   tick      out high for the single cycle the counter sits at DIV-1
module divisor_muestreo
  import secuenciador_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Habilitar,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  // Decoded from the registered count so the scheduler registers its
  // response on the same edge that wraps the counter.
  assign tick = Habilitar && (cnt == W'(DIV - 1));

  always_ff @(posedge Clk) begin
    if (Reset || !Habilitar) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/secuenciador_muestreo.sv
// secuenciador_muestreo: sample scheduler for the second-order filter.
// Each period it starts an ADC conversion, latches the sample into Uk,
// launches the filter, and latches the filter result into Salida.
// Overruns and handshake timeouts raise sticky flags.
//   Clk, Reset          clock, synchronous active-high reset
//   Habilitar           enables the sample-period counter
//   Limpiar             clears Sobrecarga and Error_Timeout
//   ADC_Listo/ADC_Dato  ADC done level and result
//   Inicio_ADC          one-cycle conversion-start pulse
//   Uk                  held sample into the filter
//   Bandera_ADC         one-cycle filter-start pulse
//   Bandera_Listo/Yk    filter done (rising edge used) and result
//   Salida/Salida_Valida held result and its one-cycle update pulse
//   Sobrecarga          sticky overrun flag
//   Error_Timeout       sticky handshake-timeout flag
//   Muestras            completed-sample counter, present only when the
//                       macro CONTADOR_MUESTRAS_EN is defined
module secuenciador_muestreo
  import secuenciador_pkg::*;
#(
  parameter int N              = 25,
  parameter int DIV            = DIV_DEF,
  parameter int TIMEOUT_ADC    = TIMEOUT_ADC_DEF,
  parameter int TIMEOUT_FILTRO = TIMEOUT_FILTRO_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Habilitar,
  input  logic         Limpiar,
  input  logic         ADC_Listo,
  input  logic [N-1:0] ADC_Dato,
  output logic         Inicio_ADC,
  output logic [N-1:0] Uk,
  output logic         Bandera_ADC,
  input  logic         Bandera_Listo,
  input  logic [N-1:0] Yk,
  output logic [N-1:0] Salida,
  output logic         Salida_Valida,
  output logic         Sobrecarga,
  output logic         Error_Timeout
`ifdef CONTADOR_MUESTRAS_EN
  ,
  output logic [15:0]  Muestras
`endif
);

  localparam int TMAX = (TIMEOUT_ADC > TIMEOUT_FILTRO) ? TIMEOUT_ADC : TIMEOUT_FILTRO;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic          tick;
  estado_t       estado;
  logic [CW-1:0] timer;
  logic          listo_q;
  logic          listo_re;

  divisor_muestreo #(
    .DIV(DIV)
  ) u_divisor (
    .Clk      (Clk),
    .Reset    (Reset),
    .Habilitar(Habilitar),
    .tick     (tick)
  );

  assign listo_re = Bandera_Listo & ~listo_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado        <= REPOSO;
      timer         <= '0;
      listo_q       <= 1'b0;
      Inicio_ADC    <= 1'b0;
      Uk            <= '0;
      Bandera_ADC   <= 1'b0;
      Salida        <= '0;
      Salida_Valida <= 1'b0;
      Sobrecarga    <= 1'b0;
      Error_Timeout <= 1'b0;
`ifdef CONTADOR_MUESTRAS_EN
      Muestras      <= '0;
`endif
    end else begin
      Inicio_ADC    <= 1'b0;
      Bandera_ADC   <= 1'b0;
      Salida_Valida <= 1'b0;
      listo_q       <= Bandera_Listo;

      // Clear first so that a set event later in this block wins.
      if (Limpiar) begin
        Sobrecarga    <= 1'b0;
        Error_Timeout <= 1'b0;
      end

      // A tick outside REPOSO is dropped, even on the completion cycle.
      if (tick && (estado != REPOSO)) begin
        Sobrecarga <= 1'b1;
      end

      case (estado)
        REPOSO: begin
          if (tick) begin
            Inicio_ADC <= 1'b1;
            timer      <= '0;
            estado     <= CONVIRTIENDO;
          end
        end
        CONVIRTIENDO: begin
          if (ADC_Listo) begin
            Uk          <= ADC_Dato;
            Bandera_ADC <= 1'b1;
            timer       <= '0;
            estado      <= FILTRANDO;
          end else if (timer == CW'(TIMEOUT_ADC - 1)) begin
            Error_Timeout <= 1'b1;
            estado        <= REPOSO;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FILTRANDO: begin
          if (listo_re) begin
            Salida        <= Yk;
            Salida_Valida <= 1'b1;
            estado        <= REPOSO;
`ifdef CONTADOR_MUESTRAS_EN
            Muestras      <= Muestras + 16'd1;
`endif
          end else if (timer == CW'(TIMEOUT_FILTRO - 1)) begin
            Error_Timeout <= 1'b1;
            estado        <= REPOSO;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          estado <= REPOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_muestreo.sv
// tb_secuenciador_muestreo: directed bench for secuenciador_muestreo with
// DIV=20 and both timeouts at 16. Cycle 0 is the first cycle after Reset
// is released; signals are sampled and driven 1 time unit after each edge.
module tb_secuenciador_muestreo;

  localparam int N = 25;

  logic         Clk;
  logic         Reset;
  logic         Habilitar;
  logic         Limpiar;
  logic         ADC_Listo;
  logic [N-1:0] ADC_Dato;
  logic         Inicio_ADC;
  logic [N-1:0] Uk;
  logic         Bandera_ADC;
  logic         Bandera_Listo;
  logic [N-1:0] Yk;
  logic [N-1:0] Salida;
  logic         Salida_Valida;
  logic         Sobrecarga;
  logic         Error_Timeout;
`ifdef CONTADOR_MUESTRAS_EN
  logic [15:0]  Muestras;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_inicio = 0;
  int n_sv     = 0;

  secuenciador_muestreo #(
    .N(N), .DIV(20), .TIMEOUT_ADC(16), .TIMEOUT_FILTRO(16)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Habilitar    (Habilitar),
    .Limpiar      (Limpiar),
    .ADC_Listo    (ADC_Listo),
    .ADC_Dato     (ADC_Dato),
    .Inicio_ADC   (Inicio_ADC),
    .Uk           (Uk),
    .Bandera_ADC  (Bandera_ADC),
    .Bandera_Listo(Bandera_Listo),
    .Yk           (Yk),
    .Salida       (Salida),
    .Salida_Valida(Salida_Valida),
    .Sobrecarga   (Sobrecarga),
    .Error_Timeout(Error_Timeout)
`ifdef CONTADOR_MUESTRAS_EN
    ,
    .Muestras     (Muestras)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
    if (Inicio_ADC === 1'b1) n_inicio++;
    if (Salida_Valida === 1'b1) n_sv++;
  endtask

  task automatic go(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_inicio"}, Inicio_ADC, 1'b0);
    chkn({tag, "_uk"}, Uk, '0);
    chk1({tag, "_bandera_adc"}, Bandera_ADC, 1'b0);
    chkn({tag, "_salida"}, Salida, '0);
    chk1({tag, "_salida_valida"}, Salida_Valida, 1'b0);
    chk1({tag, "_sobrecarga"}, Sobrecarga, 1'b0);
    chk1({tag, "_timeout"}, Error_Timeout, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; Habilitar = 1'b0; Limpiar = 1'b0;
    ADC_Listo = 1'b0; ADC_Dato = '0; Bandera_Listo = 1'b0; Yk = '0;
    repeat (3) step();
    chk_zero("reset");
`ifdef CONTADOR_MUESTRAS_EN
    chki("reset_muestras", int'(Muestras), 0);
`endif
    Reset = 1'b0; Habilitar = 1'b1;
    cyc = 0; n_inicio = 0; n_sv = 0;

    // Normal sample
    go(19); chk1("no_early_inicio", Inicio_ADC, 1'b0);
    go(20); chk1("inicio_c20", Inicio_ADC, 1'b1);
    go(21); chk1("inicio_one_cycle", Inicio_ADC, 1'b0);
    go(23); ADC_Listo = 1'b1; ADC_Dato = 25'h0000ABC;
    go(24); chkn("uk_abc", Uk, 25'h0000ABC); chk1("bandera_adc_hi", Bandera_ADC, 1'b1);
    ADC_Listo = 1'b0; ADC_Dato = '0;
    go(25); chk1("bandera_adc_one_cycle", Bandera_ADC, 1'b0); chkn("uk_held", Uk, 25'h0000ABC);
    go(29); Bandera_Listo = 1'b1; Yk = 25'h0001234;
    go(30); chkn("salida_1234", Salida, 25'h0001234); chk1("sv_hi", Salida_Valida, 1'b1);
    Bandera_Listo = 1'b0; Yk = '0;
    go(31); chk1("sv_one_cycle", Salida_Valida, 1'b0); chkn("salida_held", Salida, 25'h0001234);
    go(39); chk1("no_inicio_c39", Inicio_ADC, 1'b0);
    go(40); chk1("inicio_c40", Inicio_ADC, 1'b1);
    chk1("sob_clear_normal", Sobrecarga, 1'b0); chk1("to_clear_normal", Error_Timeout, 1'b0);
    chki("inicio_count_40", n_inicio, 2);

    // ADC silent
    go(55); chk1("to_not_yet", Error_Timeout, 1'b0);
    go(56); chk1("adc_timeout", Error_Timeout, 1'b1); chkn("salida_after_to", Salida, 25'h0001234);
    go(60); chk1("inicio_after_to", Inicio_ADC, 1'b1); chki("no_sv_after_to", n_sv, 1);
    Limpiar = 1'b1;
    go(61); chk1("limpiar_clears_to", Error_Timeout, 1'b0);
    Limpiar = 1'b0;

    // Overrun
    go(70); ADC_Listo = 1'b1; ADC_Dato = 25'h1555555;
    go(71); chkn("uk_1555555", Uk, 25'h1555555); chk1("bandera_adc_ov", Bandera_ADC, 1'b1);
    ADC_Listo = 1'b0;
    go(79); chk1("sob_before_tick", Sobrecarga, 1'b0);
    go(80); chk1("sob_set", Sobrecarga, 1'b1); chk1("no_inicio_overrun", Inicio_ADC, 1'b0);
    go(83); Bandera_Listo = 1'b1; Yk = 25'h0ABCDEF;
    go(84); chkn("salida_overrun", Salida, 25'h0ABCDEF); chk1("sv_overrun", Salida_Valida, 1'b1);
    Bandera_Listo = 1'b0;
    go(99); chki("inicio_count_99", n_inicio, 3);
    go(100); chk1("inicio_c100", Inicio_ADC, 1'b1);

    // Flag priority with a filter that never answers
    go(110); ADC_Listo = 1'b1; ADC_Dato = 25'h0000777;
    go(111); chkn("uk_777", Uk, 25'h0000777);
    ADC_Listo = 1'b0;
    go(119); Limpiar = 1'b1;
    go(120); chk1("set_beats_limpiar", Sobrecarga, 1'b1);
    go(121); chk1("limpiar_alone", Sobrecarga, 1'b0);
    Limpiar = 1'b0;
    go(126); chk1("filt_to_not_yet", Error_Timeout, 1'b0);
    go(127); chk1("filt_timeout", Error_Timeout, 1'b1);
    chkn("salida_unchanged_filt_to", Salida, 25'h0ABCDEF); chki("sv_count_127", n_sv, 2);

    // Reset in FILTRANDO, late handshake ignored
    go(140); chk1("inicio_c140", Inicio_ADC, 1'b1);
    go(142); ADC_Listo = 1'b1; ADC_Dato = 25'h0000555;
    go(143); chk1("bandera_adc_c143", Bandera_ADC, 1'b1);
    ADC_Listo = 1'b0;
    go(144); Reset = 1'b1;
    go(145); chk_zero("midreset");
    Reset = 1'b0;
    go(146); Bandera_Listo = 1'b1; Yk = 25'h1111111;
    go(150); chki("no_sv_after_reset", n_sv, 2); chkn("salida_zero_after_reset", Salida, '0);
    Bandera_Listo = 1'b0;
    go(164); chk1("no_inicio_c164", Inicio_ADC, 1'b0);
    go(165); chk1("inicio_after_reset", Inicio_ADC, 1'b1);

    // Level handshake, full-scale values
    go(166); ADC_Listo = 1'b1; ADC_Dato = 25'h1000000;
    go(167); chkn("uk_msb", Uk, 25'h1000000);
    ADC_Listo = 1'b0;
    go(168); Bandera_Listo = 1'b1; Yk = 25'h1FFFFFF;
`ifdef CONTADOR_MUESTRAS_EN
    chki("muestras_before", int'(Muestras), 0);
`endif
    go(169); chk1("sv_level", Salida_Valida, 1'b1); chkn("salida_max", Salida, 25'h1FFFFFF);
    go(178); Bandera_Listo = 1'b0;
    go(180); chki("one_sv_for_level", n_sv, 3);
    chk1("sob_level", Sobrecarga, 1'b0); chk1("to_level", Error_Timeout, 1'b0);
`ifdef CONTADOR_MUESTRAS_EN
    chki("muestras_after", int'(Muestras), 1);
`endif

    // Habilitar low holds the period counter
    Habilitar = 1'b0;
    go(230); chki("no_inicio_disabled", n_inicio, 6); chkn("salida_hold_disabled", Salida, 25'h1FFFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/secuenciador_muestreo.md
Name: secuenciador_muestreo

Overview:
Top-level sample scheduler for the second-order filter datapath. Generates the sample period and starts each ADC conversion. Latches the converted sample into Uk, pulses Bandera_ADC to launch the filter, then waits for Bandera_Listo and latches Yk into a held output register. Detects overrun and handshake timeouts with sticky flags.

Parameters:
N, 25, sample/result width (matches filter N)
DIV, 1000, sample period in Clk cycles; legal range 16..2^20
TIMEOUT_ADC, 64, max cycles from Inicio_ADC to ADC_Listo
TIMEOUT_FILTRO, 32, max cycles from Bandera_ADC to Bandera_Listo rising edge

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
Habilitar  in  1  enables the sample-period counter
Limpiar  in  1  clears the sticky flags
ADC_Listo  in  1  ADC conversion done (sampled level)
ADC_Dato  in  N  ADC result, valid while ADC_Listo=1
Inicio_ADC  out  1  one-cycle conversion-start pulse
Uk  out  N  held sample driven into the filter
Bandera_ADC  out  1  one-cycle filter-start pulse
Bandera_Listo  in  1  filter done (level or pulse; rising edge used)
Yk  in  N  filter result
Salida  out  N  held filtered output
Salida_Valida  out  1  one-cycle pulse, Salida updated
Sobrecarga  out  1  sticky overrun flag
Error_Timeout  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0, FSM=REPOSO, period counter=0, timer=0, edge register=0. Reset mid-operation aborts immediately; any late handshake is ignored.
- Period counter: increments while Habilitar=1 and is held at 0 while Habilitar=0. At DIV-1 it wraps to 0 and asserts internal tick for 1 cycle. An in-flight sample completes after Habilitar drops.
- Edge detect: Listo_re = Bandera_Listo & ~Bandera_Listo_q.
- FSM. All outputs are registered, so an effect is visible the cycle after its cause.
  - REPOSO: on tick, Inicio_ADC<=1, timer<=0, go to CONVIRTIENDO.
  - CONVIRTIENDO:
    - ADC_Listo=1: Uk<=ADC_Dato, Bandera_ADC<=1, timer<=0, go to FILTRANDO.
    - Otherwise, when timer==TIMEOUT_ADC-1: Error_Timeout<=1, go to REPOSO.
  - FILTRANDO:
    - Listo_re: Salida<=Yk, Salida_Valida<=1, go to REPOSO.
    - Otherwise, when timer==TIMEOUT_FILTRO-1: Error_Timeout<=1, go to REPOSO, Salida unchanged.
- Bandera_Listo and ADC_Listo are ignored outside their wait states.
- Overrun: a tick is accepted only in REPOSO.
  - A tick in any other state, including the cycle completion occurs, is dropped (not queued) and sets Sobrecarga<=1.
  - The FSM continues the current sample.
- Flags: Limpiar clears both flags. A set event in the same cycle wins over Limpiar.
- Uk holds its value between samples. Inicio_ADC, Bandera_ADC and Salida_Valida are never high for more than 1 cycle.
- Timer is CW=$clog2(max(TIMEOUT_ADC,TIMEOUT_FILTRO)) bits and never wraps.

Optional Feature:
Macro CONTADOR_MUESTRAS_EN.
- Defined: adds output Muestras [15:0].
  - Reset 0; increments with each Salida_Valida; wraps 16'hFFFF to 0.
  - Limpiar does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package secuenciador_pkg: FSM state encoding (REPOSO, CONVIRTIENDO, FILTRANDO, 2 bits) and default constants for DIV, TIMEOUT_ADC and TIMEOUT_FILTRO.
- One sub-module, divisor_muestreo: period counter with Habilitar hold and the tick output (params DIV; ports Clk, Reset, Habilitar, tick).

Test Plan:
- Normal sample. Setup: DIV=20, timeouts 16; Habilitar=1 from cycle 0; ADC_Listo 3 cycles after Inicio_ADC with ADC_Dato=25'h0000ABC; Bandera_Listo rises 5 cycles after Bandera_ADC with Yk=25'h0001234. Expected: Inicio_ADC at cycle 20 and 40; Uk=25'h0000ABC with a 1-cycle Bandera_ADC; Salida=25'h0001234 with a 1-cycle Salida_Valida; flags stay 0.
- ADC silent. Stimulus: ADC_Listo never asserts. Expected: Error_Timeout=1 sixteen cycles after Inicio_ADC; FSM back in REPOSO; the next tick issues Inicio_ADC; Salida unchanged, no Salida_Valida.
- Overrun. Stimulus: ADC responds after 10 cycles, filter after 12 (total > DIV=20). Expected: Sobrecarga=1 at the second tick; no second Inicio_ADC until REPOSO plus the following tick; the first sample still delivers Salida.
- Flag priority. Stimulus: Limpiar=1 in the same cycle as an overrun tick. Expected: Sobrecarga remains 1. Then Limpiar alone clears it to 0 on the next cycle.
- Reset mid-FILTRANDO. Stimulus: Reset asserted, then Bandera_Listo rises 2 cycles later. Expected: all outputs 0 the cycle after Reset; no Salida_Valida; FSM in REPOSO.
- Level handshake. Stimulus: Bandera_Listo held high for 10 cycles. Expected: exactly one Salida_Valida; with CONTADOR_MUESTRAS_EN defined, Muestras increments by 1.
